multi_mode_hex_display: RTL and testbench

//   Parametrised board-level display controller for the DE1-SoC lab designs.

---
 rtl/multi_mode_hex_display.sv | 159 +++++++++++++++
 tb/tb_multi_mode_hex_display.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_mode_hex_display.sv
// Board-level display controller: debounced keys drive a press counter, a pausable
// cycle counter and a lap snapshot; SW[9:8] picks which one is shown as hex digits.
module multi_mode_hex_display #(
    parameter int NUM_DIGITS      = 4,
    parameter int CNT_W           = 30,
    parameter int PRESS_W         = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic [9:0]              SW,
    input  logic [3:0]              KEY,
    output logic [7*NUM_DIGITS-1:0] hex_segs,
    output logic [PRESS_W-1:0]      press_cnt,
    output logic                    running
);

    localparam int SRC_W = 4 * NUM_DIGITS;
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ZERO = {DB_W{1'b0}};

    logic [3:0]            sync1_r;
    logic [3:0]            sync2_r;
    logic [3:0]            stable_r;
    logic [3:0]            stable_nxt_s;
    logic [3:0][DB_W-1:0]  db_cnt_r;
    logic [3:0][DB_W-1:0]  db_cnt_nxt_s;
    logic [3:0]            press_nxt_s;
    logic [3:0]            press_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [SRC_W-1:0]      snap_r;
    logic [PRESS_W-1:0]    press_cnt_r;
    logic                  running_r;
    logic [SRC_W-1:0]      src_s;
    logic [7*NUM_DIGITS-1:0] hex_nxt_s;
    logic [7*NUM_DIGITS-1:0] hex_segs_r;

    // Active-low seven-segment font, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_font = 7'b1000000;
            4'h1:    hex_font = 7'b1111001;
            4'h2:    hex_font = 7'b0100100;
            4'h3:    hex_font = 7'b0110000;
            4'h4:    hex_font = 7'b0011001;
            4'h5:    hex_font = 7'b0010010;
            4'h6:    hex_font = 7'b0000010;
            4'h7:    hex_font = 7'b1111000;
            4'h8:    hex_font = 7'b0000000;
            4'h9:    hex_font = 7'b0010000;
            4'hA:    hex_font = 7'b0001000;
            4'hB:    hex_font = 7'b0000011;
            4'hC:    hex_font = 7'b1000110;
            4'hD:    hex_font = 7'b0100001;
            4'hE:    hex_font = 7'b0000110;
            4'hF:    hex_font = 7'b0001110;
            default: hex_font = 7'b1111111;
        endcase
    endfunction

    // Two-flop synchroniser for the asynchronous push buttons.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
        end else begin
            sync1_r <= KEY;
            sync2_r <= sync1_r;
        end
    end

    // Per-key debounce: a disagreement must persist DEBOUNCE_CYCLES edges to be accepted.
    always_comb begin
        stable_nxt_s = stable_r;
        press_nxt_s  = 4'b0000;
        db_cnt_nxt_s = db_cnt_r;
        for (int k = 0; k < 4; k++) begin
            if (sync2_r[k] != stable_r[k]) begin
                if (db_cnt_r[k] == DB_LAST) begin
                    stable_nxt_s[k] = sync2_r[k];
                    press_nxt_s[k]  = stable_r[k];
                    db_cnt_nxt_s[k] = DB_ZERO;
                end else begin
                    db_cnt_nxt_s[k] = db_cnt_r[k] + DB_W'(1'b1);
                end
            end else begin
                db_cnt_nxt_s[k] = DB_ZERO;
            end
        end
    end

    // Debounce state and the registered one-cycle press pulses.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            stable_r <= 4'b1111;
            db_cnt_r <= {4{DB_ZERO}};
            press_r  <= 4'b0000;
        end else begin
            stable_r <= stable_nxt_s;
            db_cnt_r <= db_cnt_nxt_s;
            press_r  <= press_nxt_s;
        end
    end

    // Key actions; clear wins over lap and increment but a toggle still applies.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            running_r   <= 1'b1;
            cnt_r       <= {CNT_W{1'b0}};
            snap_r      <= {SRC_W{1'b0}};
            press_cnt_r <= {PRESS_W{1'b0}};
        end else begin
            running_r <= press_r[1] ? ~running_r : running_r;
            if (press_r[0]) begin
                cnt_r       <= {CNT_W{1'b0}};
                snap_r      <= {SRC_W{1'b0}};
                press_cnt_r <= {PRESS_W{1'b0}};
            end else begin
                cnt_r       <= running_r ? cnt_r + CNT_W'(1'b1) : cnt_r;
                // Only the displayed slice of the lap value is ever visible, so only it is kept.
                snap_r      <= press_r[2] ? cnt_r[CNT_W-1 -: SRC_W] : snap_r;
                press_cnt_r <= press_r[3] ? press_cnt_r + PRESS_W'(1'b1) : press_cnt_r;
            end
        end
    end

    // Display source select; SW is deliberately used without synchronisation.
    always_comb begin
        case (SW[9:8])
            2'b00:   src_s = SRC_W'(SW[7:0]);
            2'b01:   src_s = SRC_W'(press_cnt_r);
            2'b10:   src_s = cnt_r[CNT_W-1 -: SRC_W];
            default: src_s = snap_r;
        endcase
    end

    // Nibble i of the source drives digit i.
    always_comb begin
        hex_nxt_s = {(7*NUM_DIGITS){1'b1}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            hex_nxt_s[7*i +: 7] = hex_font(src_s[4*i +: 4]);
        end
    end

    // Registered segment drive, blank during reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hex_segs_r <= {(7*NUM_DIGITS){1'b1}};
        end else begin
            hex_segs_r <= hex_nxt_s;
        end
    end

    assign hex_segs  = hex_segs_r;
    assign press_cnt = press_cnt_r;
    assign running   = running_r;

endmodule

// File: tb/tb_multi_mode_hex_display.sv
// Directed and randomised bench for multi_mode_hex_display; every cycle is compared
// against an integer-level reference model of keys, counters and display.
module tb_multi_mode_hex_display;

    localparam int ND = 4;
    localparam int CW = 20;
    localparam int PW = 8;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [9:0]    sw;
    logic [3:0]    key;
    logic [27:0]   hex_segs;
    logic [PW-1:0] press_cnt;
    logic          running;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, kept as plain integers.
    int          m_seen1 [4];
    int          m_seen2 [4];
    int          m_stable[4];
    int          m_run   [4];
    int          m_pend  [4];
    int          m_pc = 0;
    int          m_cnt = 0;
    int          m_snap = 0;
    int          m_running = 1;
    logic [27:0] m_hex = 28'hFFFFFFF;

    always #5 clk = ~clk;

    multi_mode_hex_display #(
        .NUM_DIGITS(ND), .CNT_W(CW), .PRESS_W(PW), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .SW       (sw),
        .KEY      (key),
        .hex_segs (hex_segs),
        .press_cnt(press_cnt),
        .running  (running)
    );

    function automatic logic [6:0] font(input int n);
        case (n)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
           12: return 7'h46; 13: return 7'h21; 14: return 7'h06; 15: return 7'h0E;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge of the reference model, using the inputs present at that edge.
    task automatic model_edge();
        int src;
        logic [27:0] hx;
        int n_stable[4];
        int n_run[4];
        int n_pend[4];
        case (sw[9:8])
            2'd0:    src = int'(sw[7:0]);
            2'd1:    src = m_pc;
            2'd2:    src = m_cnt / 16;
            default: src = m_snap / 16;
        endcase
        for (int i = 0; i < ND; i++) hx[7*i +: 7] = font((src >> (4*i)) % 16);
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                m_seen1[k] = 0; m_seen2[k] = 0; m_stable[k] = 1; m_run[k] = 0; m_pend[k] = 0;
            end
            m_pc = 0; m_cnt = 0; m_snap = 0; m_running = 1;
            m_hex = 28'hFFFFFFF;
        end else begin
            if (m_pend[0] == 1) begin
                m_snap = 0;
                m_pc   = 0;
                m_cnt  = 0;
            end else begin
                if (m_pend[2] == 1) m_snap = m_cnt;
                if (m_pend[3] == 1) m_pc = (m_pc + 1) % (1 << PW);
                if (m_running == 1) m_cnt = (m_cnt + 1) % (1 << CW);
            end
            if (m_pend[1] == 1) m_running = 1 - m_running;
            for (int k = 0; k < 4; k++) begin
                n_stable[k] = m_stable[k];
                n_run[k]    = 0;
                n_pend[k]   = 0;
                if (m_seen2[k] != m_stable[k]) begin
                    // accepted once the disagreement has lasted DB consecutive edges
                    if (m_run[k] + 1 == DB) begin
                        n_stable[k] = m_seen2[k];
                        n_pend[k]   = (m_stable[k] == 1) ? 1 : 0;
                    end else begin
                        n_run[k] = m_run[k] + 1;
                    end
                end
                m_stable[k] = n_stable[k];
                m_run[k]    = n_run[k];
                m_pend[k]   = n_pend[k];
                m_seen2[k]  = m_seen1[k];
                m_seen1[k]  = int'(key[k]);
            end
            m_hex = hx;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("hex_segs",  32'(hex_segs),  32'(m_hex));
        chk("press_cnt", 32'(press_cnt), 32'(m_pc));
        chk("running",   32'(running),   32'(m_running));
    endtask

    task automatic press(input int k, input int lo, input int hi);
        key[k] = 1'b0;
        repeat (lo) tick();
        key[k] = 1'b1;
        repeat (hi) tick();
    endtask

    initial begin
        int waited;
        int idx;
        reset = 1'b1;
        key   = 4'hF;
        sw    = 10'h000;
        repeat (3) tick();
        chk("reset_hex",     32'(hex_segs),  32'h0FFFFFFF);
        chk("reset_press",   32'(press_cnt), 32'h0);
        chk("reset_running", 32'(running),   32'h1);

        reset = 1'b0;
        sw    = 10'h0A5;
        tick();
        chk("sw_0a5_hex", 32'(hex_segs), 32'({7'h40, 7'h40, 7'h08, 7'h12}));
        repeat (8) begin
            sw = {2'b00, 8'($urandom)};
            tick();
        end

        // short bounce must not count, a held press must
        sw     = 10'h100;
        key[3] = 1'b0;
        repeat (2) tick();
        key[3] = 1'b1;
        repeat (10) tick();
        chk("bounce_no_press", 32'(press_cnt), 32'h0);
        key[3] = 1'b0;
        waited = 0;
        while (waited < 7 && press_cnt !== 8'd1) begin
            tick();
            waited++;
        end
        chk("press_latency", 32'(press_cnt), 32'h1);
        repeat (3) tick();
        key[3] = 1'b1;
        repeat (8) tick();

        // wrap the press counter back to zero, with occasional bounces
        for (int p = 0; p < 255; p++) begin
            if ($urandom_range(0, 3) == 0) begin
                key[3] = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
                key[3] = 1'b1;
                repeat (2) tick();
            end
            press(3, $urandom_range(6, 8), $urandom_range(6, 8));
        end
        repeat (10) tick();
        chk("wrap_press_cnt", 32'(press_cnt), 32'h0);
        chk("wrap_hex",       32'(hex_segs),  32'({4{7'h40}}));

        // pause, hold frozen, resume
        sw = 10'h200;
        repeat (5) tick();
        press(1, 7, 7);
        chk("paused", 32'(running), 32'h0);
        repeat (100) tick();
        press(1, 7, 7);
        chk("resumed", 32'(running), 32'h1);
        repeat (20) tick();

        // lap snapshot holds while the live counter moves on
        sw = 10'h300;
        repeat (3) tick();
        press(2, 7, 7);
        repeat (10) tick();
        sw = 10'h200;
        repeat (50) tick();
        sw = 10'h300;
        repeat (10) tick();

        // simultaneous clear and increment
        sw = 10'h100;
        repeat (3) press(3, 7, 7);
        key = 4'b0110;
        repeat (7) tick();
        key = 4'hF;
        repeat (8) tick();
        chk("clr_press_cnt", 32'(press_cnt), 32'h0);
        sw = 10'h300;
        tick();
        chk("clr_snap_hex", 32'(hex_segs), 32'({4{7'h40}}));
        sw = 10'h200;
        tick();
        chk("clr_cnt_hex", 32'(hex_segs), 32'({4{7'h40}}));

        // clear together with toggle, then toggle back
        key = 4'b1100;
        repeat (7) tick();
        key = 4'hF;
        repeat (8) tick();
        chk("clr_toggle_running", 32'(running), 32'h0);
        press(1, 7, 7);

        // reset in the middle of a debounce discards the pending press
        sw = 10'h100;
        press(3, 7, 7);
        key[3] = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        key   = 4'hF;
        repeat (2) tick();
        reset = 1'b0;
        repeat (15) tick();
        chk("rst_mid_debounce", 32'(press_cnt), 32'h0);

        // random key activity and mode changes
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                idx = $urandom_range(0, 3);
                key[idx] = ~key[idx];
            end
            if ($urandom_range(0, 15) == 0) sw = 10'($urandom);
            tick();
        end
        key = 4'hF;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
